// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: FSM state encodings and port ids shared by the memory arbiter files.
package mem_arb_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational two-port grant; the pointer names the port that wins a tie.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic gnt_valid,
  output logic gnt_id
);
  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = (ptr == PORT0) ? (req0 ? PORT0 : PORT1) : (req1 ? PORT1 : PORT0);
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port single-memory arbiter, IDLE->ACCESS->RESP per transaction.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin priority; otherwise port 0 always wins.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_LIMIT = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] addr0,
  input  logic [DATA_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              we0,
  input  logic              we1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_e            state_q, state_d;
  logic              id_q, we_q;
  logic [DATA_W-1:0] addr_q, wdata_q, rdata_q;
  logic              ptr, gnt_valid, gnt_id, oor, grant;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic ptr_q;
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= PORT0;
    else if (grant) ptr_q <= ~gnt_id;
  end
  assign ptr = ptr_q;
`else
  assign ptr = PORT0;
`endif

  mem_arb_pick u_pick (
    .req0      (req0),
    .req1      (req1),
    .ptr       (ptr),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign grant = (state_q == IDLE) && gnt_valid;
  assign oor   = addr_q >= DATA_W'(ADDR_LIMIT);

  always_comb begin
    state_d   = (state_q == IDLE) ? (gnt_valid ? ACCESS : IDLE) :
                (state_q == ACCESS) ? RESP : IDLE;
    mem_read  = (state_q == ACCESS) && !we_q && !oor;
    mem_write = (state_q == ACCESS) && we_q && !oor;
    ack0      = (state_q == RESP) && (id_q == PORT0);
    ack1      = (state_q == RESP) && (id_q == PORT1);
    err0      = ack0 && oor;
    err1      = ack1 && oor;
  end

  // The latched request doubles as the memory-side address/data, so they hold between accesses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      id_q    <= PORT0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        id_q    <= gnt_id;
        we_q    <= gnt_id ? we1 : we0;
        addr_q  <= gnt_id ? addr1 : addr0;
        wdata_q <= gnt_id ? wdata1 : wdata0;
      end
      if (mem_read) rdata_q <= mem_rdata;
    end
  end

  assign rdata     = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter with a behavioural memory model.
module tb_mem_arbiter;
  typedef struct {
    logic        we;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic        clk = 0, reset = 1;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic        ack0, ack1, err0, err1, mem_read, mem_write;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  exp_t        q0[$], q1[$];
  int          ack_log[$];
  logic [31:0] last_rd = 0;
  int          rd_cnt = 0, wr_cnt = 0;
  bit          cont_mode = 0;
  int          checks = 0, errors = 0;

  mem_arbiter #(.DATA_W(32), .ADDR_LIMIT(256)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .we0(we0), .we1(we1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr < 256) ? mem[mem_addr[7:0]] : 32'h0;
  always @(posedge clk) if (mem_write && mem_addr < 256) mem[mem_addr[7:0]] <= mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic issue(input int p, input logic [31:0] a, input logic [31:0] d,
                       input logic w, input bit chk_lat);
    exp_t e;
    int   n;
    e.we   = w;
    e.err  = a >= 256;
    e.data = e.err ? 32'h0 : ref_mem[a[7:0]];
    if (w && !e.err) ref_mem[a[7:0]] = d;
    if (p == 0) q0.push_back(e); else q1.push_back(e);
    @(posedge clk); #1;
    if (p == 0) begin req0 = 1; addr0 = a; wdata0 = d; we0 = w; end
    else begin req1 = 1; addr1 = a; wdata1 = d; we1 = w; end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(p == 0 ? ack0 : ack1) && n < 60);
    chk($sformatf("ack_seen_p%0d", p), 32'(n < 60), 1);
    if (chk_lat && n < 60) chk($sformatf("latency_p%0d", p), n, 3);
    @(posedge clk); #1;
    if (p == 0) req0 = 0; else req1 = 0;
  endtask

  task automatic rand_port(input int p);
    logic [31:0] a;
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(9, 0) == 0) a = $urandom_range(4000, 256);
      else a = (p == 0) ? $urandom_range(127, 10) : $urandom_range(255, 128);
      issue(p, a, $urandom, 1'($urandom_range(1, 0)), 0);
      repeat ($urandom_range(3, 0)) @(posedge clk);
    end
  endtask

  // Monitor: strobes are tallied per transaction and settled against the scoreboard at each ack.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (reset) begin
      rd_cnt = 0; wr_cnt = 0; last_rd = 0;
    end else begin
      rd_cnt += int'(mem_read);
      wr_cnt += int'(mem_write);
      if (ack0 && ack1) chk("single_ack", {ack0, ack1}, 2'b01);
      if (ack0 || ack1) begin
        if (cont_mode) begin
          ack_log.push_back(int'(ack1));
          chk("cont_err", {err0, err1}, 0);
        end else if ((ack0 ? q0.size() : q1.size()) == 0) begin
          chk(ack0 ? "pending_p0" : "pending_p1", ack0 ? q0.size() : q1.size(), 1);
        end else begin
          e = ack0 ? q0.pop_front() : q1.pop_front();
          if (!e.we && !e.err) last_rd = e.data;
          chk("err", ack0 ? err0 : err1, e.err);
          chk("rdata", rdata, last_rd);
          chk("rd_strobes", rd_cnt, 32'(!e.we && !e.err));
          chk("wr_strobes", wr_cnt, 32'(e.we && !e.err));
        end
        rd_cnt = 0; wr_cnt = 0;
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = (i * 32'h01010101) ^ 32'hA5A50000;
      ref_mem[i] = mem[i];
    end
    mem[5] = 32'hDEADBEEF;
    ref_mem[5] = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {ack0, ack1, err0, err1}, 0);
    chk("rst_strobes", {mem_read, mem_write}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    reset = 0;

    issue(0, 5, 0, 0, 1);
    issue(1, 9, 32'h12345678, 1, 1);
    issue(1, 9, 0, 0, 1);
    chk("wr_mem9", mem[9], 32'h12345678);
    issue(0, 300, 32'h55AA55AA, 1, 1);
    issue(0, 300, 0, 0, 1);

    fork
      rand_port(0);
      rand_port(1);
    join

    @(posedge clk); #1;
    req0 = 1; addr0 = 7; wdata0 = 32'hCAFE0007; we0 = 1;
    @(posedge clk); #1;
    chk("acc_write", mem_write, 1);
    reset = 1; req0 = 0;
    @(posedge clk); #1;
    chk("abort_strobes", {mem_read, mem_write}, 0);
    chk("abort_ack", {ack0, ack1}, 0);
    reset = 0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_no_ack", {ack0, ack1}, 0);
    end
    chk("abort_rdata", rdata, 0);
    issue(1, 200, 0, 0, 1);

    cont_mode = 1;
    @(posedge clk); #1;
    req0 = 1; addr0 = 3; we0 = 0; req1 = 1; addr1 = 130; we1 = 0;
    repeat (12) @(posedge clk);
    #1;
    req0 = 0; req1 = 0;
    repeat (4) @(posedge clk);
    #1;
    cont_mode = 0;
    chk("cont_count", ack_log.size(), 4);
    for (int i = 0; i < 4 && i < ack_log.size(); i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      chk($sformatf("cont_id%0d", i), ack_log[i], i % 2);
`else
      chk($sformatf("cont_id%0d", i), ack_log[i], 0);
`endif
    end

    repeat (3) @(posedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
